dmem_arbiter: RTL and testbench

- Two-port arbiter that shares the single data-memory/IO port between requester 0 (CPU datapath) and requester 1 (debug/loader or DMA master).
- Sequences each access as a fixed 3-cycle transaction: arbitrate, access, acknowledge.
- Registers the read data and checks addresses against the memory map.
- Sits between the requesters and the data memory/IO block; the memory read is combinational and the write occurs on the posedge.

---
 rtl/dmem_arbiter_if.sv | 61 ++++++
 rtl/dmem_arbiter.sv | 159 +++++++++++++++
 tb/tb_dmem_arbiter.sv | 222 ++++++++++++++++++++++
 3 files changed

// File: rtl/dmem_arbiter_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : dmem_arbiter_if                                                 |
// | Purpose  : Bundles the two requester handshakes, the shared memory/IO    |
// |            port and the arbiter status signals of dmem_arbiter.          |
// | Ports    : req/we/addr/wdata   requester -> arbiter (per requester 0/1)   |
// |            ack/rdata/err       arbiter -> requester (per requester 0/1)   |
// |            mem_addr/mem_wdata/mem_write/mem_read  arbiter -> memory/IO    |
// |            mem_rdata           memory/IO -> arbiter (combinational)       |
// |            busy/owner          arbiter status                             |
// | Modports : slave  - the arbiter itself                                    |
// |            master - the surrounding environment (requesters + memory)    |
// | Revision : 1.0  initial release                                           |
// +--------------------------------------------------------------------------+
interface dmem_arbiter_if;
  logic        req0;
  logic        we0;
  logic [15:0] addr0;
  logic [15:0] wdata0;
  logic        ack0;
  logic [15:0] rdata0;
  logic        err0;

  logic        req1;
  logic        we1;
  logic [15:0] addr1;
  logic [15:0] wdata1;
  logic        ack1;
  logic [15:0] rdata1;
  logic        err1;

  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic        mem_write;
  logic        mem_read;
  logic [15:0] mem_rdata;

  logic        busy;
  logic        owner;

  modport slave (
    input  req0, we0, addr0, wdata0,
    input  req1, we1, addr1, wdata1,
    input  mem_rdata,
    output ack0, rdata0, err0,
    output ack1, rdata1, err1,
    output mem_addr, mem_wdata, mem_write, mem_read,
    output busy, owner
  );

  modport master (
    output req0, we0, addr0, wdata0,
    output req1, we1, addr1, wdata1,
    output mem_rdata,
    input  ack0, rdata0, err0,
    input  ack1, rdata1, err1,
    input  mem_addr, mem_wdata, mem_write, mem_read,
    input  busy, owner
  );
endinterface
`default_nettype wire

// File: rtl/dmem_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : dmem_arbiter                                                    |
// | Purpose  : Shares one data-memory/IO port between requester 0 (CPU) and  |
// |            requester 1 (loader/DMA). Each access is a fixed three-cycle  |
// |            IDLE -> GNT -> ACK transaction; the address is checked        |
// |            against the memory map and read data is registered.           |
// | Ports    : clock  - system clock, all state on posedge                   |
// |            reset  - synchronous, active-high                             |
// |            bus    - dmem_arbiter_if.slave (requesters, memory, status)   |
// | Options  : DMEM_ARB_RR_EN defined   -> round-robin on contention         |
// |            DMEM_ARB_RR_EN undefined -> requester 0 has fixed priority    |
// | Revision : 1.0  initial release                                           |
// +--------------------------------------------------------------------------+
module dmem_arbiter #(
  parameter logic [15:0] MEM_LO = 16'd64,
  parameter logic [15:0] MEM_HI = 16'd126,
  parameter logic [15:0] IO_IN  = 16'hFFF0,
  parameter logic [15:0] IO_OUT = 16'hFFFA
) (
  input wire logic      clock,
  input wire logic      reset,
  dmem_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_GNT  = 2'd1,
    ST_ACK  = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic        r_owner;
  logic        w_owner_nxt;

  logic [15:0] r_rdata0;
  logic [15:0] r_rdata1;
  logic        r_err0;
  logic        r_err1;

  // Request fields of whichever requester currently holds the grant.
  logic        w_we;
  logic [15:0] w_addr;
  logic [15:0] w_wdata;
  logic        w_legal;

  logic        w_tie_pick;
  logic        w_grant;

  logic [15:0] w_mem_addr;
  logic [15:0] w_mem_wdata;
  logic        w_mem_write;
  logic        w_mem_read;

  logic [15:0] w_rdata_new;
  logic        w_err_new;

  assign w_we    = r_owner ? bus.we1    : bus.we0;
  assign w_addr  = r_owner ? bus.addr1  : bus.addr0;
  assign w_wdata = r_owner ? bus.wdata1 : bus.wdata0;

  // Even address inside the RAM window, or the direction-specific IO ports.
  assign w_legal = ~w_addr[0] &
                   (((w_addr >= MEM_LO) && (w_addr <= MEM_HI)) ||
                    ((w_addr == IO_IN)  && !w_we) ||
                    ((w_addr == IO_OUT) &&  w_we));

`ifdef DMEM_ARB_RR_EN
  // Contention goes to whoever was not served last, so it alternates.
  assign w_tie_pick = ~r_owner;
`else
  // Contention always goes to the CPU; requester 1 may starve.
  assign w_tie_pick = 1'b0;
`endif

  assign w_grant = (bus.req0 && bus.req1) ? w_tie_pick : bus.req1;

  // Value captured for the owner at the end of GNT.
  assign w_rdata_new = (w_legal && !w_we) ? bus.mem_rdata : 16'h0000;
  assign w_err_new   = ~w_legal;

  always_comb begin
    w_state_nxt = r_state;
    w_owner_nxt = r_owner;
    w_mem_addr  = 16'h0000;
    w_mem_wdata = 16'h0000;
    w_mem_write = 1'b0;
    w_mem_read  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (bus.req0 || bus.req1) begin
          w_state_nxt = ST_GNT;
          w_owner_nxt = w_grant;
        end
      end
      ST_GNT: begin
        w_mem_addr  = w_addr;
        w_mem_wdata = w_wdata;
        if (w_legal) begin
          // Gating with reset keeps a reset landing in this cycle from
          // committing a write that will never be acknowledged.
          w_mem_write = w_we & ~reset;
          w_mem_read  = ~w_we;
        end
        w_state_nxt = ST_ACK;
      end
      ST_ACK: begin
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state  <= ST_IDLE;
      r_owner  <= 1'b1;
      r_rdata0 <= 16'h0000;
      r_rdata1 <= 16'h0000;
      r_err0   <= 1'b0;
      r_err1   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_owner <= w_owner_nxt;
      if (r_state == ST_GNT) begin
        if (r_owner) begin
          r_rdata1 <= w_rdata_new;
          r_err1   <= w_err_new;
        end else begin
          r_rdata0 <= w_rdata_new;
          r_err0   <= w_err_new;
        end
      end
      // Error flag is only meaningful alongside ack.
      if (r_state == ST_ACK) begin
        r_err0 <= 1'b0;
        r_err1 <= 1'b0;
      end
    end
  end

  assign bus.ack0      = (r_state == ST_ACK) & ~r_owner;
  assign bus.ack1      = (r_state == ST_ACK) &  r_owner;
  assign bus.rdata0    = r_rdata0;
  assign bus.rdata1    = r_rdata1;
  assign bus.err0      = r_err0;
  assign bus.err1      = r_err1;
  assign bus.mem_addr  = w_mem_addr;
  assign bus.mem_wdata = w_mem_wdata;
  assign bus.mem_write = w_mem_write;
  assign bus.mem_read  = w_mem_read;
  assign bus.busy      = (r_state != ST_IDLE);
  assign bus.owner     = r_owner;

endmodule
`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_dmem_arbiter                                                 |
// | Purpose  : Directed scoreboard bench for dmem_arbiter with a small       |
// |            memory/IO model (RAM 64..126, switches at FFF0, display FFFA).|
// | Revision : 1.0  initial release                                           |
// +--------------------------------------------------------------------------+
module tb_dmem_arbiter;

  logic clock;
  logic reset;

  dmem_arbiter_if bus ();

  dmem_arbiter dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // ---------------- memory / IO model ----------------
  logic [15:0] mem [0:31];
  logic [15:0] sw;
  logic [15:0] disp;
  logic        w_in_ram;

  assign w_in_ram = (bus.mem_addr >= 16'd64) && (bus.mem_addr <= 16'd127);
  assign bus.mem_rdata = !bus.mem_read              ? 16'hDEAD :
                         (bus.mem_addr == 16'hFFF0) ? sw :
                         w_in_ram                   ? mem[bus.mem_addr[5:1]] :
                                                      16'hBAD0;

  always @(posedge clock) begin
    if (bus.mem_write) begin
      if (w_in_ram) mem[bus.mem_addr[5:1]] <= bus.mem_wdata;
      else if (bus.mem_addr == 16'hFFFA) disp <= bus.mem_wdata;
    end
  end

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  // ---------------- scoreboard ----------------
  typedef struct packed {
    logic        who;
    logic [15:0] rdata;
    logic        err;
  } exp_t;

  exp_t exp_q[$];
  int   n_vec  = 0;
  int   n_fail = 0;
  logic spacing_chk = 1'b0;
  int   last_ack_cyc = -1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge clock) begin
    exp_t e;
    logic who;
    if (bus.ack0 || bus.ack1) begin
      who = bus.ack1;
      if (bus.ack0 && bus.ack1) chk("dual_ack", 32'd1, 32'd0);
      if (exp_q.size() == 0) begin
        n_vec++;
        n_fail++;
        $display("FAIL unexpected_ack: got ack on requester %0d, expected none", who);
      end else begin
        e = exp_q.pop_front();
        chk("ack_who", 32'(who), 32'(e.who));
        chk("ack_rdata", 32'(who ? bus.rdata1 : bus.rdata0), 32'(e.rdata));
        chk("ack_err", 32'(who ? bus.err1 : bus.err0), 32'(e.err));
      end
      if (spacing_chk && last_ack_cyc >= 0) chk("ack_spacing", 32'(cyc - last_ack_cyc), 32'd3);
      last_ack_cyc = cyc;
    end
    if (!spacing_chk) last_ack_cyc = -1;
  end

  // ---------------- stimulus ----------------
  task automatic drive(input logic who, input logic req, input logic we,
                       input logic [15:0] addr, input logic [15:0] wdata);
    if (who) begin
      bus.req1 = req; bus.we1 = we; bus.addr1 = addr; bus.wdata1 = wdata;
    end else begin
      bus.req0 = req; bus.we0 = we; bus.addr0 = addr; bus.wdata0 = wdata;
    end
  endtask

  // Single uncontended transaction, started at a negedge with the DUT idle.
  task automatic txn(input logic who, input logic we, input logic [15:0] addr,
                     input logic [15:0] wdata, input logic legal,
                     input logic [15:0] exp_rdata, input logic drop_early);
    drive(who, 1'b1, we, addr, wdata);
    exp_q.push_back('{who: who, rdata: exp_rdata, err: !legal});
    @(negedge clock);  // GNT
    chk("gnt_busy", 32'(bus.busy), 32'd1);
    chk("gnt_owner", 32'(bus.owner), 32'(who));
    chk("gnt_addr", 32'(bus.mem_addr), 32'(addr));
    chk("gnt_wdata", 32'(bus.mem_wdata), 32'(wdata));
    chk("gnt_write", 32'(bus.mem_write), 32'(legal & we));
    chk("gnt_read", 32'(bus.mem_read), 32'(legal & !we));
    if (drop_early) drive(who, 1'b0, we, addr, wdata);
    @(negedge clock);  // ACK
    chk("ack_latency", 32'(who ? bus.ack1 : bus.ack0), 32'd1);
    chk("ack_mem_write", 32'(bus.mem_write), 32'd0);
    drive(who, 1'b0, we, addr, wdata);
    @(negedge clock);  // back in IDLE
    chk("idle_busy", 32'(bus.busy), 32'd0);
    chk("idle_ack", 32'(who ? bus.ack1 : bus.ack0), 32'd0);
    chk("idle_err", 32'(who ? bus.err1 : bus.err0), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int acks;
    sw   = 16'h0002;
    disp = 16'h0000;
    drive(1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
    drive(1'b1, 1'b0, 1'b0, 16'h0, 16'h0);
    reset = 1'b1;
    repeat (2) @(negedge clock);

    // Reset state
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_owner", 32'(bus.owner), 32'd1);
    chk("rst_ack", 32'({bus.ack0, bus.ack1}), 32'd0);
    chk("rst_err", 32'({bus.err0, bus.err1}), 32'd0);
    chk("rst_rdata0", 32'(bus.rdata0), 32'd0);
    chk("rst_rdata1", 32'(bus.rdata1), 32'd0);
    chk("rst_mem", 32'({bus.mem_read, bus.mem_write, bus.mem_addr, bus.mem_wdata}), 32'd0);
    reset = 1'b0;

    // 1: write then read back
    txn(1'b0, 1'b1, 16'd64, 16'h1234, 1'b1, 16'h0000, 1'b0);
    txn(1'b0, 1'b0, 16'd64, 16'h0000, 1'b1, 16'h1234, 1'b0);

    // 3: illegal accesses
    txn(1'b0, 1'b1, 16'd65,   16'h5555, 1'b0, 16'h0000, 1'b0);
    txn(1'b0, 1'b0, 16'hFFFA, 16'h0000, 1'b0, 16'h0000, 1'b0);
    txn(1'b0, 1'b1, 16'd128,  16'h7777, 1'b0, 16'h0000, 1'b0);
    txn(1'b0, 1'b1, 16'hFFF0, 16'h0001, 1'b0, 16'h0000, 1'b0);
    // upper RAM bound and display port are legal
    txn(1'b0, 1'b1, 16'd126,  16'h0F0F, 1'b1, 16'h0000, 1'b0);
    txn(1'b0, 1'b1, 16'hFFFA, 16'h00C3, 1'b1, 16'h0000, 1'b0);
    chk("display", 32'(disp), 32'h00C3);
    txn(1'b0, 1'b0, 16'd64, 16'h0000, 1'b1, 16'h1234, 1'b0);

    // 2: requester 1 reads the switches, requester 0 data held
    txn(1'b1, 1'b0, 16'hFFF0, 16'h0000, 1'b1, 16'h0002, 1'b0);
    chk("rdata0_held", 32'(bus.rdata0), 32'h1234);

    // 4: sustained contention, owner is 1 going in
`ifdef DMEM_ARB_RR_EN
    exp_q.push_back('{who: 1'b0, rdata: 16'h1234, err: 1'b0});
    exp_q.push_back('{who: 1'b1, rdata: 16'h0002, err: 1'b0});
    exp_q.push_back('{who: 1'b0, rdata: 16'h1234, err: 1'b0});
    exp_q.push_back('{who: 1'b1, rdata: 16'h0002, err: 1'b0});
`else
    repeat (4) exp_q.push_back('{who: 1'b0, rdata: 16'h1234, err: 1'b0});
`endif
    drive(1'b0, 1'b1, 1'b0, 16'd64, 16'h0000);
    drive(1'b1, 1'b1, 1'b0, 16'hFFF0, 16'h0000);
    spacing_chk = 1'b1;
    acks = 0;
    for (int i = 0; i < 40 && acks < 4; i++) begin
      @(negedge clock);
      if (bus.ack0 || bus.ack1) acks++;
    end
    chk("contention_acks", 32'(acks), 32'd4);
    drive(1'b0, 1'b0, 1'b0, 16'd64, 16'h0000);
    drive(1'b1, 1'b0, 1'b0, 16'hFFF0, 16'h0000);
    @(negedge clock);
    spacing_chk = 1'b0;
    chk("contention_idle", 32'(bus.busy), 32'd0);
    chk("contention_drained", 32'(exp_q.size()), 32'd0);

    // 5: reset during the GNT cycle of a write
    txn(1'b0, 1'b1, 16'd80, 16'h5A5A, 1'b1, 16'h0000, 1'b0);
    txn(1'b0, 1'b0, 16'd80, 16'h0000, 1'b1, 16'h5A5A, 1'b0);
    drive(1'b0, 1'b1, 1'b1, 16'd80, 16'hBEEF);
    @(negedge clock);  // GNT
    reset = 1'b1;
    #1;
    chk("rst_gnt_write", 32'(bus.mem_write), 32'd0);
    drive(1'b0, 1'b0, 1'b1, 16'd80, 16'hBEEF);
    @(negedge clock);
    chk("rst_mid_ack0", 32'(bus.ack0), 32'd0);
    chk("rst_mid_busy", 32'(bus.busy), 32'd0);
    chk("rst_mid_owner", 32'(bus.owner), 32'd1);
    chk("rst_mid_rdata0", 32'(bus.rdata0), 32'd0);
    chk("rst_mid_err0", 32'(bus.err0), 32'd0);
    chk("rst_mid_mem", 32'({bus.mem_read, bus.mem_write, bus.mem_addr}), 32'd0);
    reset = 1'b0;
    @(negedge clock);
    txn(1'b0, 1'b0, 16'd80, 16'h0000, 1'b1, 16'h5A5A, 1'b0);

    // 6: request dropped during GNT still completes
    txn(1'b0, 1'b0, 16'd64, 16'h0000, 1'b1, 16'h1234, 1'b1);
    repeat (2) @(negedge clock);
    chk("final_drained", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
